// File: rtl/rv64m_div_unit_if.sv
// Request/response bundle between the execute stage and the divide unit.
// The unit is the slave; the issuing stage (or bench) is the master.
interface rv64m_div_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      funct3;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, a, b, funct3, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, funct3, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/rv64m_div_unit.sv
// RV64M DIV/DIVU/REM/REMU unit: radix-2 restoring divider, one quotient bit per cycle,
// with divide-by-zero and signed-overflow results resolved at accept time.
module rv64m_div_unit #(
  parameter int XLEN = 64
) (
  input logic             clk,
  input logic             rst_n,
  rv64m_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;

  logic            signed_in;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] fix_sel;
  logic            fix_neg;
  logic            unused_funct3;

  // funct3[0] set means unsigned; bit 2 carries no information for these ops.
  assign signed_in     = ~bus.funct3[0];
  assign unused_funct3 = bus.funct3[2];
  assign a_abs = (signed_in && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign b_abs = (signed_in && bus.b[XLEN-1]) ? -bus.b : bus.b;

  // Remainder shifted left with the next dividend bit, minus the divisor, one bit wider
  // so the sign bit tells whether the subtract fits.
  assign trial   = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};
  assign fix_sel = op_q[1] ? rem_q : quo_q;
  assign fix_neg = ~op_q[0] & (op_q[1] ? r_neg_q : q_neg_q);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d    = bus.funct3[1:0];
            q_neg_d = bus.a[XLEN-1] ^ bus.b[XLEN-1];
            r_neg_d = bus.a[XLEN-1];
            if (bus.b == '0) begin
              result_d    = bus.funct3[1] ? bus.a : '1;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end else if (signed_in && bus.a == MIN_NEG && bus.b == '1) begin
              result_d    = bus.funct3[1] ? '0 : bus.a;
              out_valid_d = 1'b1;
              state_d     = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = a_abs;
              div_d   = b_abs;
              cnt_d   = '0;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          result_d    = fix_neg ? -fix_sel : fix_sel;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_rv64m_div_unit.sv
// Directed bench for rv64m_div_unit: latency, special cases, backpressure,
// flush and asynchronous reset mid-operation.
module tb_rv64m_div_unit;
  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rv64m_div_unit_if #(.XLEN(64)) bus ();

  rv64m_div_unit #(.XLEN(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for in_ready, present the request; returns just after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [63:0] av, input logic [63:0] bv);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // First sampled negedge after the accept edge is cycle 1.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(f3, av, bv);
    wait_out(lat);
    $display("[TB] %s a=%h b=%h result=%h latency=%0d", tag, av, bv, bus.result, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, bus.result, exp);
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, bus.busy, bus.in_ready}, 64'd1);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.funct3    = F_DIVU;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result",    bus.result, 64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
    check("rst_busy",      {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7",  F_DIVU, 64'd100, 64'd7, 64'd14, 66);
    run_op("remu_100_7",  F_REMU, 64'd100, 64'd7, 64'd2, 66);
    run_op("div_m7_2",    F_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("rem_m7_2",    F_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("rem_7_m2",    F_REM, 64'd7, -64'sd2, 64'd1, 66);
    run_op("div_5_0",     F_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_5_0",    F_REMU, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf",     F_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf",     F_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("divu_ovf_ops", F_DIVU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66);

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    issue(F_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    wait_out(lat);
    $display("[TB] bp_divu a=ffffffffffffffff b=3 result=%h latency=%0d", bus.result, lat);
    check("bp_lat", 64'(lat), 64'd66);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_hold", {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
      check("bp_res", bus.result, 64'h5555_5555_5555_5555);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

    // Flush in CALC cycle 30 with a competing request that must not be taken.
    issue(F_DIVU, 64'd100, 64'd7);
    repeat (30) @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.funct3   = F_DIVU;
    bus.a        = 64'd9;
    bus.b        = 64'd3;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] flush at cycle 30 in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
    check("flush_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    watch_quiet("flush_quiet", 80);
    run_op("divu_9_3_flush", F_DIVU, 64'd9, 64'd3, 64'd3, 66);

    // Asynchronous reset pulse in CALC cycle 30.
    issue(F_DIVU, 64'd100, 64'd7);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_state", {61'd0, bus.in_ready, bus.busy, bus.out_valid}, 64'd4);
    check("arst_result", bus.result, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset at cycle 30 in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
    check("arst_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    watch_quiet("arst_quiet", 80);
    run_op("divu_9_3_rst", F_DIVU, 64'd9, 64'd3, 64'd3, 66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
